// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI pin-sharing arbiter.
// State encoding is fixed so that debug probes of the state register are stable.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    GUARD = 2'd0,
    IDLE  = 2'd1,
    FLASH = 2'd2,
    SR    = 2'd3
  } arb_state_e;

  localparam logic BUS_SEL_FLASH = 1'b0;
  localparam logic BUS_SEL_SR    = 1'b1;

endpackage

// File: rtl/spi_arb_timer.sv
// Loadable, saturating down-counter. 'expire' marks the last cycle of an interval:
// a counter loaded with N and decremented every cycle asserts it on its N-th cycle.
module spi_arb_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == W'(1)) || (count == '0);

endmodule

// File: rtl/spi_share_arb.sv
// Arbiter for the shared flash / LED shift-register SPI pins with an idle guard gap.
// Optional starvation protection for the shift-register side: define SPI_ARB_STARVE_EN.
module spi_share_arb
  import spi_arb_pkg::*;
#(
  parameter int GUARD_CYC  = 4,
  parameter int MAX_WAIT   = 64,
  parameter int SR_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flash_req,
  input  logic flash_csn_o,
  output logic flash_gnt,
  input  logic sr_req,
  input  logic sr_done,
  output logic sr_gnt,
  output logic bus_sel,
  output logic bus_idle,
  output logic err_sr_timeout
);

  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam int TW = $clog2(SR_TIMEOUT + 1);

  if (GUARD_CYC < 1 || GUARD_CYC > 255 || MAX_WAIT < 1 || SR_TIMEOUT < 2) begin : g_bad_param
    $error("spi_share_arb: parameter out of range");
  end

  arb_state_e state, state_next;
  logic       guard_load, guard_expire;
  logic       grant_flash, grant_sr;
  logic       to_expire, timeout_fire;
  logic       starve;

  // Guard gap: loaded on every release, counts down while in GUARD.
  spi_arb_timer #(.W(GW), .RST_VAL(GW'(GUARD_CYC))) u_guard_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (guard_load),
    .load_val (GW'(GUARD_CYC)),
    .dec      (state == GUARD),
    .expire   (guard_expire)
  );

  // SR ownership watchdog: the SR_TIMEOUT-th owned cycle without sr_done forces release.
  spi_arb_timer #(.W(TW), .RST_VAL('0)) u_sr_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant_sr),
    .load_val (TW'(SR_TIMEOUT)),
    .dec      (state == SR),
    .expire   (to_expire)
  );

`ifdef SPI_ARB_STARVE_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (grant_sr) begin
      wait_cnt <= '0;
    end else if (sr_req && state != SR && wait_cnt != WW'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign starve = (wait_cnt == WW'(MAX_WAIT));
`else
  assign starve = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    guard_load   = 1'b0;
    grant_flash  = 1'b0;
    grant_sr     = 1'b0;
    timeout_fire = 1'b0;
    unique case (state)
      GUARD: begin
        if (guard_expire) state_next = IDLE;
      end
      IDLE: begin
        if (starve && sr_req) begin
          grant_sr   = 1'b1;
          state_next = SR;
        end else if (flash_req) begin
          grant_flash = 1'b1;
          state_next  = FLASH;
        end else if (sr_req) begin
          grant_sr   = 1'b1;
          state_next = SR;
        end
      end
      FLASH: begin
        // Preemption only between flash transactions (chip-select high).
        if (!flash_req || (starve && flash_csn_o)) begin
          guard_load = 1'b1;
          state_next = GUARD;
        end
      end
      SR: begin
        // A dropped sr_req counts as completion; completion beats the watchdog.
        if (sr_done || !sr_req) begin
          guard_load = 1'b1;
          state_next = GUARD;
        end else if (to_expire) begin
          guard_load   = 1'b1;
          timeout_fire = 1'b1;
          state_next   = GUARD;
        end
      end
      default: state_next = GUARD;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= GUARD;
      flash_gnt      <= 1'b0;
      sr_gnt         <= 1'b0;
      bus_sel        <= BUS_SEL_FLASH;
      bus_idle       <= 1'b1;
      err_sr_timeout <= 1'b0;
    end else begin
      state          <= state_next;
      flash_gnt      <= (state_next == FLASH);
      sr_gnt         <= (state_next == SR);
      bus_idle       <= !(state_next == FLASH || state_next == SR);
      err_sr_timeout <= timeout_fire;
      if (grant_sr) begin
        bus_sel <= BUS_SEL_SR;
      end else if (grant_flash) begin
        bus_sel <= BUS_SEL_FLASH;
      end
    end
  end

endmodule
